lamp_bank_arbiter: RTL and testbench
====================================

LAMP_BANK_ARBITER -- requirements
Module: lamp_bank_arbiter

Interface
REQ-001 Parameter N_REQ, default 3: number of pattern requesters sharing the lamp bank (2..8).
REQ-002 Parameter LAMP_W, default 16: lamp bank width.
REQ-003 Parameter DWELL, default 8: minimum cycles a grant is held once issued.
REQ-004 Parameter WDOG, default 256: maximum cycles a single grant may last.
REQ-005 clk  input  1  rising-edge clock for all state.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 req  input  N_REQ  per-requester level request for the lamp bank.
REQ-008 done  input  N_REQ  per-requester single-cycle "pattern finished" pulse.
REQ-009 pattern_i  input  N_REQ*LAMP_W  requester k drives slice [k*LAMP_W +: LAMP_W].
REQ-010 gnt  output  N_REQ  one-hot grant, all-zero when no owner.
REQ-011 lamps  output  LAMP_W  registered lamp bank drive.
REQ-012 busy  output  1  high while any grant is active.
REQ-013 wdog_trip  output  1  single-cycle pulse when the watchdog revokes a grant.

Function
REQ-014 The FSM SHALL have three states: IDLE, GRANT and BLANK.
REQ-015 IDLE: if any eligible req, the winner SHALL be chosen round-robin starting at (last+1) mod N_REQ; gnt SHALL assert on the next edge and the state SHALL move to GRANT; otherwise remain in IDLE with lamps=0.
REQ-016 Request-to-grant latency SHALL be exactly 1 cycle from an idle bank.
REQ-017 GRANT: each cycle lamps SHALL register the granted slice of pattern_i (1-cycle lag); other slices SHALL be ignored.
REQ-018 Dwell counter SHALL clear on grant and increment each GRANT cycle, saturating at DWELL-1.
REQ-019 done[g] SHALL be latched into done_pend; release SHALL occur on the first cycle with done_pend=1 and dwell count = DWELL-1.
REQ-020 If req[g] drops during GRANT, release SHALL occur on the next edge regardless of dwell.
REQ-021 done on non-granted requesters SHALL be ignored and SHALL NOT be latched.
REQ-022 On release: gnt SHALL go all-zero, lamps SHALL be 0, state SHALL enter BLANK for exactly one cycle, then IDLE.
REQ-023 last SHALL update to the released index; a requester still holding req SHALL lose priority to all other pending requesters.
REQ-024 busy SHALL equal |gnt.

Reset
REQ-025 On rst_n low, asynchronously: state=IDLE, gnt=0, lamps=0, busy=0, wdog_trip=0, dwell=0, done_pend=0, last=N_REQ-1, mask=0.
REQ-026 Reset asserted mid-grant SHALL abort the grant with no BLANK cycle; first arbitration after release of rst_n selects from index 0 upward.

Configuration
REQ-027 Macro LAMP_ARB_WDOG_EN defined: a watchdog counter SHALL count GRANT cycles; on reaching WDOG-1, release SHALL be forced as per REQ-022, wdog_trip SHALL pulse for 1 cycle, and the offender's mask bit SHALL set.
REQ-028 A masked requester SHALL be ineligible until its req is observed low, which clears its mask bit.
REQ-029 Macro undefined: no watchdog or mask logic; wdog_trip SHALL be tied 0.

Structure
REQ-030 Shared package lamp_pkg SHALL hold LAMP_W default, the state enum (IDLE, GRANT, BLANK) and the one-hot-to-index function.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs: eligible vector, last index; outputs: one-hot winner, valid).

Verification
REQ-032 Reset, then req=3'b111 simultaneously -> gnt=001 one cycle later; after each done+dwell release, grants follow 010 then 100, each separated by one BLANK cycle with lamps=0.
REQ-033 Grant to req[1], pattern slice 1 = 16'h00FF, done pulsed at cycle 2 -> lamps=16'h00FF from grant+1, release exactly at dwell cycle 7, not earlier.
REQ-034 req[0] dropped at grant cycle 3 -> gnt=000 next edge, lamps=0, BLANK, IDLE.
REQ-035 rst_n pulled low during GRANT with lamps=16'hFFFF -> lamps, gnt and busy zero immediately without waiting for clk.
REQ-036 LAMP_ARB_WDOG_EN, WDOG=16, req[2] held with no done -> wdog_trip pulse at grant cycle 15, req[2] not re-granted until req[2] low for one cycle; other requesters served meanwhile.

Source files
------------

// File: rtl/lamp_pkg.sv
// Shared types for the lamp bank arbiter: default width, FSM states, one-hot decode.
package lamp_pkg;

    localparam int LAMP_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BLANK = 2'd2
    } lamp_state_e;

    // Up to 8 requesters; callers zero-extend and truncate to their own index width.
    function automatic logic [2:0] oh2idx(input logic [7:0] oh);
        logic [2:0] r;
        r = '0;
        for (int i = 0; i < 8; i++)
            if (oh[i]) r = 3'(i);
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first eligible requester after `last`, wrapping modulo N.
module rr_pick #(
    parameter int N  = 3,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  elig,
    input  logic [IW-1:0] last,
    output logic [N-1:0]  win,
    output logic          vld
);

    logic [IW-1:0] idx;

    always_comb begin
        win = '0;
        vld = 1'b0;
        idx = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IW'((int'(last) + i) % N);
            if (!vld && elig[idx]) begin
                win[idx] = 1'b1;
                vld      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/lamp_bank_arbiter.sv
// Lamp bank arbiter: round-robin ownership of a shared lamp bank with dwell and BLANK gap.
// Define LAMP_ARB_WDOG_EN to add the grant watchdog and per-requester lockout mask.
module lamp_bank_arbiter
    import lamp_pkg::*;
#(
    parameter int N_REQ  = 3,
    parameter int LAMP_W = LAMP_W_DEF,
    parameter int DWELL  = 8,
    parameter int WDOG   = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [N_REQ-1:0]        done,
    input  logic [N_REQ*LAMP_W-1:0] pattern_i,
    output logic [N_REQ-1:0]        gnt,
    output logic [LAMP_W-1:0]       lamps,
    output logic                    busy,
    output logic                    wdog_trip
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int DW = $clog2(DWELL + 1);
    localparam logic [DW-1:0] DWELL_MAX = DW'(DWELL - 1);

    lamp_state_e                   state, state_nxt;
    logic [N_REQ-1:0]              gnt_nxt, elig, win;
    logic [LAMP_W-1:0]             lamps_nxt;
    logic [DW-1:0]                 dwell, dwell_nxt;
    logic                          done_pend, done_pend_nxt;
    logic [IW-1:0]                 last, last_nxt, gidx;
    logic                          win_vld, rel, trip;
    logic [N_REQ-1:0][LAMP_W-1:0]  pat;

`ifdef LAMP_ARB_WDOG_EN
    localparam int WW = $clog2(WDOG + 1);
    localparam logic [WW-1:0] WDOG_MAX = WW'(WDOG - 1);
    logic [WW-1:0]    wcnt, wcnt_nxt;
    logic [N_REQ-1:0] mask, mask_nxt;
    assign elig = req & ~mask;
`else
    assign elig = req;
`endif

    assign pat       = pattern_i;
    assign gidx      = IW'(oh2idx(8'(gnt)));
    assign busy      = |gnt;
    assign wdog_trip = trip;

    rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
        .elig (elig),
        .last (last),
        .win  (win),
        .vld  (win_vld)
    );

    always_comb begin
        state_nxt     = state;
        gnt_nxt       = gnt;
        lamps_nxt     = lamps;
        dwell_nxt     = dwell;
        done_pend_nxt = done_pend;
        last_nxt      = last;
        rel           = 1'b0;
`ifdef LAMP_ARB_WDOG_EN
        wcnt_nxt      = wcnt;
        trip          = (state == GRANT) && (wcnt == WDOG_MAX);
`else
        trip          = 1'b0;
`endif
        case (state)
            IDLE: begin
                lamps_nxt = '0;
                if (win_vld) begin
                    gnt_nxt       = win;
                    state_nxt     = GRANT;
                    dwell_nxt     = '0;
                    done_pend_nxt = 1'b0;
`ifdef LAMP_ARB_WDOG_EN
                    wcnt_nxt      = '0;
`endif
                end
            end
            GRANT: begin
                lamps_nxt = pat[gidx];
                if (dwell != DWELL_MAX) dwell_nxt = dwell + 1'b1;
                if (|(done & gnt)) done_pend_nxt = 1'b1;
`ifdef LAMP_ARB_WDOG_EN
                wcnt_nxt = wcnt + 1'b1;
`endif
                // A dropped request releases at once; a finished pattern waits out the dwell.
                rel = !(|(req & gnt)) || (done_pend && dwell == DWELL_MAX) || trip;
                if (rel) begin
                    gnt_nxt       = '0;
                    lamps_nxt     = '0;
                    state_nxt     = BLANK;
                    last_nxt      = gidx;
                    done_pend_nxt = 1'b0;
                end
            end
            BLANK: begin
                lamps_nxt = '0;
                state_nxt = IDLE;
            end
            default: begin
                gnt_nxt   = '0;
                lamps_nxt = '0;
                state_nxt = IDLE;
            end
        endcase
`ifdef LAMP_ARB_WDOG_EN
        // Lockout persists until the offender is seen with req low.
        mask_nxt = (mask | (trip ? gnt : '0)) & req;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt       <= '0;
            lamps     <= '0;
            dwell     <= '0;
            done_pend <= 1'b0;
            last      <= IW'(N_REQ - 1);
`ifdef LAMP_ARB_WDOG_EN
            wcnt      <= '0;
            mask      <= '0;
`endif
        end else begin
            state     <= state_nxt;
            gnt       <= gnt_nxt;
            lamps     <= lamps_nxt;
            dwell     <= dwell_nxt;
            done_pend <= done_pend_nxt;
            last      <= last_nxt;
`ifdef LAMP_ARB_WDOG_EN
            wcnt      <= wcnt_nxt;
            mask      <= mask_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_lamp_bank_arbiter.sv
// Directed bench for lamp_bank_arbiter: round-robin order, dwell release, req drop, async reset, watchdog.
module tb_lamp_bank_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, done, gnt;
    logic [47:0] pattern_i;
    logic [15:0] lamps;
    logic        busy, wdog_trip;

    int nchk = 0;
    int nfail = 0;

    logic [15:0] slice [3];

    always #5 clk = ~clk;

    lamp_bank_arbiter #(.N_REQ(3), .LAMP_W(16), .DWELL(8), .WDOG(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .done      (done),
        .pattern_i (pattern_i),
        .gnt       (gnt),
        .lamps     (lamps),
        .busy      (busy),
        .wdog_trip (wdog_trip)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nfail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        slice[0] = 16'h1111;
        slice[1] = 16'h00FF;
        slice[2] = 16'hF0F0;
        pattern_i = {slice[2], slice[1], slice[0]};
        req = '0; done = '0; rst_n = 1'b0;
        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_lamps", lamps, 0);
        chk("rst_busy", busy, 0);
        chk("rst_trip", wdog_trip, 0);
        rst_n = 1'b1;
        step();

        // All three request together: 001, 010, 100 each after done + dwell.
        req = 3'b111;
        step();
        for (int g = 0; g < 3; g++) begin
            chk("rr_gnt", gnt, 32'(1 << g));
            chk("rr_busy", busy, 1);
            chk("rr_lamps_c0", lamps, 0);
            done = 3'(1 << g);
            step();
            done = '0;
            chk("rr_lamps_c1", lamps, slice[g]);
            repeat (6) step();
            chk("rr_hold_c7", gnt, 32'(1 << g));
            step();
            chk("rr_blank_gnt", gnt, 0);
            chk("rr_blank_lamps", lamps, 0);
            if (g == 2) req = '0;
            step();
            chk("rr_idle_gnt", gnt, 0);
            step();
        end
        chk("rr_end_busy", busy, 0);

        // Single requester 1, done at grant cycle 2, release at dwell cycle 7.
        req = 3'b010;
        step();
        chk("dw_gnt", gnt, 3'b010);
        step();
        chk("dw_lamps", lamps, 16'h00FF);
        step();
        done = 3'b010;
        step();
        done = '0;
        repeat (3) step();
        chk("dw_hold_c6", gnt, 3'b010);
        step();
        chk("dw_hold_c7", gnt, 3'b010);
        step();
        chk("dw_rel_c8", gnt, 0);
        chk("dw_rel_lamps", lamps, 0);
        req = '0;
        repeat (2) step();

        // done on non-granted requesters must not release the owner.
        req = 3'b001;
        step();
        chk("ng_gnt", gnt, 3'b001);
        done = 3'b110;
        step();
        done = '0;
        repeat (9) step();
        chk("ng_hold_c10", gnt, 3'b001);
        req = '0;
        step();
        chk("ng_drop_gnt", gnt, 0);
        chk("ng_drop_lamps", lamps, 0);
        step();

        // req[0] dropped at grant cycle 3; new req raised in BLANK waits one IDLE cycle.
        req = 3'b001;
        step();
        chk("drop_gnt", gnt, 3'b001);
        repeat (3) step();
        req = '0;
        step();
        chk("drop_gnt_c4", gnt, 0);
        chk("drop_lamps_c4", lamps, 0);
        chk("drop_busy_c4", busy, 0);
        req = 3'b010;
        step();
        chk("blank_one_idle", gnt, 0);
        step();
        chk("after_blank_gnt", gnt, 3'b010);

        // Async reset mid-grant with lamps all ones.
        slice[1] = 16'hFFFF;
        pattern_i = {slice[2], slice[1], slice[0]};
        step();
        chk("ar_lamps_pre", lamps, 16'hFFFF);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_lamps", lamps, 0);
        chk("ar_gnt", gnt, 0);
        chk("ar_busy", busy, 0);
        req = 3'b011;
        step();
        rst_n = 1'b1;
        step();
        chk("ar_first_pick", gnt, 3'b001);
        req = '0;
        repeat (3) step();

`ifdef LAMP_ARB_WDOG_EN
        // Watchdog: req[2] held with no done.
        req = 3'b100;
        step();
        chk("wd_gnt", gnt, 3'b100);
        repeat (14) step();
        chk("wd_trip_c14", wdog_trip, 0);
        step();
        chk("wd_trip_c15", wdog_trip, 1);
        chk("wd_gnt_c15", gnt, 3'b100);
        step();
        chk("wd_rel_gnt", gnt, 0);
        chk("wd_trip_c16", wdog_trip, 0);
        req = 3'b101;
        step();
        chk("wd_idle", gnt, 0);
        step();
        chk("wd_other", gnt, 3'b001);
        req = 3'b100;
        repeat (3) step();
        chk("wd_masked", gnt, 0);
        req = '0;
        step();
        req = 3'b100;
        chk("wd_unmask_idle", gnt, 0);
        step();
        chk("wd_regrant", gnt, 3'b100);
        req = '0;
        repeat (3) step();
`else
        // No watchdog: a long grant is never revoked.
        req = 3'b100;
        step();
        chk("nw_gnt", gnt, 3'b100);
        repeat (20) step();
        chk("nw_hold", gnt, 3'b100);
        chk("nw_trip", wdog_trip, 0);
        req = '0;
        repeat (3) step();
`endif
        chk("end_busy", busy, 0);

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
